// File: rtl/dual_issue_ctrl_stage.sv
// Dual-slot control decoder (slot 1 ALU, slot 2 mem/branch/jump) with a one-entry registered output.
// Latency: 1 cycle from accept to out_valid; controls hold while out_valid && !out_ready.
// Backpressure: in_ready = !exc_valid && (!out_valid || out_ready); an illegal bundle blocks issue until exc_ack.
//
// Optional build macro: CTRL_PERF_CNT_EN adds saturating bundle_cnt / nop_slot_cnt outputs.
// Ports: clk, rst_n (async active-low); in_valid/in_ready + opcode1/opcode2 input bundle;
//        flush drops the registered word; out_valid/out_ready + slot-1/slot-2 control outputs;
//        exc_valid/exc_cause/exc_opcode1/exc_opcode2 + exc_ack illegal-opcode exception.
module dual_issue_ctrl_stage #(
    parameter int OP1_W = 7,
    parameter int OP2_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP1_W-1:0] opcode1,
    input  logic [OP2_W-1:0] opcode2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             regWrite1,
    output logic             flagWrite1,
    output logic             g1DstReg,
    output logic [1:0]       aluSrc1,
    output logic [1:0]       aluSrc2,
    output logic [1:0]       aluOp,
    output logic             regWrite2,
    output logic             flagWrite2,
    output logic             memRd,
    output logic             memWr,
    output logic             branch,
    output logic             jump,
    output logic             exc_valid,
    output logic [1:0]       exc_cause,
    output logic [OP1_W-1:0] exc_opcode1,
    output logic [OP2_W-1:0] exc_opcode2,
`ifdef CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0] bundle_cnt,
    output logic [CNT_W-1:0] nop_slot_cnt,
`endif
    input  logic             exc_ack
);

    typedef struct packed {
        logic       rw1;
        logic       fw1;
        logic       g1;
        logic [1:0] src1;
        logic [1:0] src2;
        logic [1:0] op;
        logic       rw2;
        logic       fw2;
        logic       mem_rd;
        logic       mem_wr;
        logic       br;
        logic       jmp;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      ctrl_q;
    logic       legal1;
    logic       legal2;
    logic       nop1;
    logic       nop2;
    logic [4:0] op5;
    logic       accept;
    logic       illegal;

    // Only the top five and low two bits of opcode1 and the low five of opcode2 carry meaning.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^{opcode1, opcode2};

    assign op5 = opcode1[OP1_W-1 -: 5];

    always_comb begin
        dec    = '0;
        legal1 = 1'b1;
        legal2 = 1'b1;
        nop1   = 1'b0;
        nop2   = 1'b0;

        case (op5)
            5'b00100: begin // add
                dec.rw1  = 1'b1;
                dec.fw1  = 1'b1;
                dec.src2 = 2'b10;
                dec.op   = 2'b01;
            end
            5'b00011: begin // sub
                dec.rw1  = 1'b1;
                dec.fw1  = 1'b1;
                dec.g1   = 1'b1;
                dec.src1 = 2'b01;
                dec.op   = 2'b10;
            end
            5'b01000: begin // cmp/shift: only the 01 sub-op writes back
                dec.rw1  = (opcode1[1:0] == 2'b01);
                dec.fw1  = 1'b1;
                dec.g1   = 1'b1;
                dec.src1 = 2'b10;
                dec.src2 = 2'b01;
                dec.op   = 2'b11;
            end
            5'b00000: nop1 = 1'b1;
            default:  legal1 = 1'b0;
        endcase

        case (opcode2[4:0])
            5'b10001: begin // load
                dec.rw2    = 1'b1;
                dec.fw2    = 1'b1;
                dec.mem_rd = 1'b1;
            end
            5'b10000: dec.mem_wr = 1'b1;
            5'b11100: dec.jmp    = 1'b1;
            5'b11010: dec.br     = 1'b1;
            5'b00000: nop2       = 1'b1;
            default:  legal2     = 1'b0;
        endcase
    end

    assign illegal  = !legal1 || !legal2;
    assign in_ready = !exc_valid && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Priority: flush > accept (legal issue / illegal squash) > plain consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            ctrl_q      <= '0;
            exc_valid   <= 1'b0;
            exc_cause   <= 2'b00;
            exc_opcode1 <= '0;
            exc_opcode2 <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
                ctrl_q    <= '0;
            end else if (accept && !illegal) begin
                out_valid <= 1'b1;
                ctrl_q    <= dec;
            end else if (accept) begin
                // Whole bundle squashed: the legal slot must not issue on its own.
                out_valid   <= 1'b0;
                ctrl_q      <= '0;
                exc_valid   <= 1'b1;
                exc_cause   <= {!legal2, !legal1};
                exc_opcode1 <= opcode1;
                exc_opcode2 <= opcode2;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                ctrl_q    <= '0;
            end

            // No accept can occur while exc_valid is set, so this never races the latch above.
            if (exc_valid && exc_ack) begin
                exc_valid <= 1'b0;
                exc_cause <= 2'b00;
            end
        end
    end

    assign regWrite1  = ctrl_q.rw1;
    assign flagWrite1 = ctrl_q.fw1;
    assign g1DstReg   = ctrl_q.g1;
    assign aluSrc1    = ctrl_q.src1;
    assign aluSrc2    = ctrl_q.src2;
    assign aluOp      = ctrl_q.op;
    assign regWrite2  = ctrl_q.rw2;
    assign flagWrite2 = ctrl_q.fw2;
    assign memRd      = ctrl_q.mem_rd;
    assign memWr      = ctrl_q.mem_wr;
    assign branch     = ctrl_q.br;
    assign jump       = ctrl_q.jmp;

`ifdef CTRL_PERF_CNT_EN
    logic [1:0]     nop_n;
    logic [CNT_W:0] nop_sum;
    logic           count_en;

    assign count_en = accept && !illegal && !flush;
    assign nop_n    = {1'b0, nop1} + {1'b0, nop2};
    // One extra bit catches overflow so the counter can clamp instead of wrapping.
    assign nop_sum  = {1'b0, nop_slot_cnt} + {{(CNT_W-1){1'b0}}, nop_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_cnt   <= '0;
            nop_slot_cnt <= '0;
        end else if (count_en) begin
            if (bundle_cnt != {CNT_W{1'b1}}) begin
                bundle_cnt <= bundle_cnt + 1'b1;
            end
            nop_slot_cnt <= nop_sum[CNT_W] ? {CNT_W{1'b1}} : nop_sum[CNT_W-1:0];
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl_stage.sv
module tb_dual_issue_ctrl_stage;

`ifdef CTRL_PERF_CNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] opcode1;
    logic [4:0] opcode2;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic       regWrite1, flagWrite1, g1DstReg;
    logic [1:0] aluSrc1, aluSrc2, aluOp;
    logic       regWrite2, flagWrite2, memRd, memWr, branch, jump;
    logic       exc_valid;
    logic [1:0] exc_cause;
    logic [6:0] exc_opcode1;
    logic [4:0] exc_opcode2;
    logic       exc_ack;
`ifdef CTRL_PERF_CNT_EN
    logic [TB_CNT_W-1:0] bundle_cnt, nop_slot_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dual_issue_ctrl_stage #(.OP1_W(7), .OP2_W(5), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode1(opcode1), .opcode2(opcode2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .regWrite1(regWrite1), .flagWrite1(flagWrite1), .g1DstReg(g1DstReg),
        .aluSrc1(aluSrc1), .aluSrc2(aluSrc2), .aluOp(aluOp),
        .regWrite2(regWrite2), .flagWrite2(flagWrite2), .memRd(memRd), .memWr(memWr),
        .branch(branch), .jump(jump),
        .exc_valid(exc_valid), .exc_cause(exc_cause),
        .exc_opcode1(exc_opcode1), .exc_opcode2(exc_opcode2),
`ifdef CTRL_PERF_CNT_EN
        .bundle_cnt(bundle_cnt), .nop_slot_cnt(nop_slot_cnt),
`endif
        .exc_ack(exc_ack)
    );

    // {rw1,fw1,g1,src1,src2,op,rw2,fw2,memRd,memWr,branch,jump}
    function automatic logic [14:0] ctrl_word();
        return {regWrite1, flagWrite1, g1DstReg, aluSrc1, aluSrc2, aluOp,
                regWrite2, flagWrite2, memRd, memWr, branch, jump};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] o1, input logic [4:0] o2);
        in_valid = v;
        opcode1  = o1;
        opcode2  = o2;
    endtask

    // Expected control words, hand-derived from the decode table.
    localparam logic [14:0] W_ADD_LOAD   = {3'b110, 2'b00, 2'b10, 2'b01, 6'b111000};
    localparam logic [14:0] W_CMP1_NOP   = {3'b111, 2'b10, 2'b01, 2'b11, 6'b000000};
    localparam logic [14:0] W_CMP0_STORE = {3'b011, 2'b10, 2'b01, 2'b11, 6'b000100};
    localparam logic [14:0] W_SUB_JUMP   = {3'b111, 2'b01, 2'b00, 2'b10, 6'b000001};
    localparam logic [14:0] W_NOP_BR     = {3'b000, 2'b00, 2'b00, 2'b00, 6'b000010};

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; exc_ack = 1'b0;
        drive(1'b0, 7'b0, 5'b0);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_exc_valid", exc_valid, 0);
        check("rst_ctrl", ctrl_word(), 0);
        step();
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);

        // add + load
        drive(1'b1, 7'b0010000, 5'b10001);
        step();
        check("add_load_valid", out_valid, 1);
        check("add_load_ctrl", ctrl_word(), W_ADD_LOAD);

        // cmp/shift writeback depends on opcode1[1:0]; back-to-back issue
        drive(1'b1, 7'b0100001, 5'b00000);
        step();
        check("cmp01_ctrl", ctrl_word(), W_CMP1_NOP);
        drive(1'b1, 7'b0100000, 5'b10000);
        step();
        check("cmp00_store_ctrl", ctrl_word(), W_CMP0_STORE);

        // Backpressure: held word stays, new bundle waits
        out_ready = 1'b0;
        drive(1'b1, 7'b0001100, 5'b11100);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ctrl", ctrl_word(), W_CMP0_STORE);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        drive(1'b0, 7'b0, 5'b0);
        check("bp_issue_ctrl", ctrl_word(), W_SUB_JUMP);
        step();
        check("consume_valid", out_valid, 0);
        check("consume_ctrl", ctrl_word(), 0);

        // Both slots illegal
        drive(1'b1, 7'b1111100, 5'b01111);
        step();
        drive(1'b1, 7'b0000000, 5'b11010);
        check("exc_valid", exc_valid, 1);
        check("exc_cause_both", exc_cause, 2'b11);
        check("exc_op1", exc_opcode1, 7'b1111100);
        check("exc_op2", exc_opcode2, 5'b01111);
        check("exc_out_valid", out_valid, 0);
        check("exc_in_ready", in_ready, 0);
        step();
        check("exc_blocks_issue", out_valid, 0);
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        check("ack_clears_valid", exc_valid, 0);
        check("ack_clears_cause", exc_cause, 0);
        check("ack_noissue_yet", out_valid, 0);
        check("ack_in_ready", in_ready, 1);
        step();
        drive(1'b0, 7'b0, 5'b0);
        check("resume_valid", out_valid, 1);
        check("resume_ctrl", ctrl_word(), W_NOP_BR);

        // Slot-2 only illegal, slot-1 legal add: no partial issue
        drive(1'b1, 7'b0010000, 5'b00001);
        step();
        drive(1'b0, 7'b0, 5'b0);
        check("exc2_cause", exc_cause, 2'b10);
        check("exc2_no_partial", ctrl_word(), 0);
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        check("exc2_cleared", exc_valid, 0);

        // Flush drops a legal accept
        drive(1'b1, 7'b0010000, 5'b10001);
        flush = 1'b1;
        step();
        check("flush_legal_valid", out_valid, 0);
        // Flush suppresses an illegal accept's exception
        drive(1'b1, 7'b1111100, 5'b01111);
        step();
        flush = 1'b0;
        drive(1'b0, 7'b0, 5'b0);
        check("flush_illegal_noexc", exc_valid, 0);

        // Mid-stream reset
        drive(1'b1, 7'b0010000, 5'b10001);
        step();
        drive(1'b0, 7'b0, 5'b0);
        check("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_ctrl", ctrl_word(), 0);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 1);

`ifdef CTRL_PERF_CNT_EN
        check("cnt_rst_bundle", bundle_cnt, 0);
        check("cnt_rst_nop", nop_slot_cnt, 0);
        step();
        drive(1'b1, 7'b0000000, 5'b10001);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("cnt_flush_bundle", bundle_cnt, 0);
        check("cnt_flush_nop", nop_slot_cnt, 0);
        step();
        check("cnt_one_bundle", bundle_cnt, 1);
        check("cnt_one_nop", nop_slot_cnt, 1);
        for (int i = 0; i < 4; i++) step();
        drive(1'b0, 7'b0, 5'b0);
        check("cnt_sat_bundle", bundle_cnt, 3);
        check("cnt_sat_nop", nop_slot_cnt, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
